// File: rtl/game_controller.sv
// Game sequencer for the reaction game: IDLE -> READY -> PLAY -> OVER state machine,
// 1 Hz prescaler, countdown timer, scoring strobes and session high score.
module game_controller #(
    parameter int CLK_HZ        = 100000000,
    parameter int READY_SECONDS = 3,
    parameter int GAME_SECONDS  = 30
) (
    input  logic       clkIn,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       hit_event,
    input  logic [5:0] score_in,
    output logic [1:0] state,
    output logic       gameStart,
    output logic       timer_expired,
    output logic       player_scored,
    output logic [5:0] time_left,
    output logic       game_active,
    output logic [5:0] high_score
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READY = 2'b01,
        PLAY  = 2'b10,
        OVER  = 2'b11
    } state_t;

    localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_HZ - 1);
    localparam logic [5:0]    READY_LEN = 6'(READY_SECONDS);
    localparam logic [5:0]    GAME_LEN  = 6'(GAME_SECONDS);

    state_t        cur_state, nxt_state;
    logic [PW-1:0] prescale, prescale_nxt;
    logic [5:0]    time_left_nxt, high_score_nxt;
    logic          game_start_nxt, expired_nxt, scored_nxt, active_nxt;
    logic          counting, tick;

    assign state    = cur_state;
    assign counting = (cur_state == READY) || (cur_state == PLAY);
    assign tick     = counting && (prescale == PRE_MAX);

    always_comb begin
        nxt_state      = cur_state;
        time_left_nxt  = time_left;
        high_score_nxt = high_score;
        game_start_nxt = 1'b0;
        expired_nxt    = 1'b0;
        scored_nxt     = hit_event && (cur_state == PLAY);
        case (cur_state)
            IDLE: begin
                if (start_btn) begin
                    nxt_state      = READY;
                    time_left_nxt  = READY_LEN;
                    game_start_nxt = 1'b1;
                end
            end
            READY: begin
                if (tick) begin
                    if (time_left == 6'd1) begin
                        nxt_state     = PLAY;
                        time_left_nxt = GAME_LEN;
                    end else begin
                        time_left_nxt = time_left - 6'd1;
                    end
                end
            end
            PLAY: begin
                if (tick) begin
                    if (time_left == 6'd1) begin
                        nxt_state     = OVER;
                        time_left_nxt = 6'd0;
                        expired_nxt   = 1'b1;
                    end else begin
                        time_left_nxt = time_left - 6'd1;
                    end
                end
            end
            OVER: begin
                // score_counter output lags the last hit, so keep sampling all through OVER
                if (score_in > high_score) high_score_nxt = score_in;
                if (start_btn) begin
                    nxt_state      = READY;
                    time_left_nxt  = READY_LEN;
                    game_start_nxt = 1'b1;
                end
            end
            default: begin
                nxt_state     = IDLE;
                time_left_nxt = 6'd0;
            end
        endcase

        active_nxt = (nxt_state == PLAY);

        // Each phase starts its seconds count from a clean zero
        if ((nxt_state != cur_state) || !counting || tick) prescale_nxt = '0;
        else                                                 prescale_nxt = prescale + PW'(1);
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            cur_state     <= IDLE;
            prescale      <= '0;
            time_left     <= 6'd0;
            high_score    <= 6'd0;
            gameStart     <= 1'b0;
            timer_expired <= 1'b0;
            player_scored <= 1'b0;
            game_active   <= 1'b0;
        end else begin
            cur_state     <= nxt_state;
            prescale      <= prescale_nxt;
            time_left     <= time_left_nxt;
            high_score    <= high_score_nxt;
            gameStart     <= game_start_nxt;
            timer_expired <= expired_nxt;
            player_scored <= scored_nxt;
            game_active   <= active_nxt;
        end
    end

endmodule
